// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Brief    : MEM-stage load/store unit for a MIPS pipeline. Accepts byte-
//            addressed requests over valid/ready and drives a single-port
//            word-wide data memory. Supports byte/half/word loads with sign
//            or zero extension. Sub-word stores use read-modify-write.
//            Misaligned requests are rejected without any memory access.
// Options  : DMEM_LSU_BOUNDS_CHECK_EN - when defined, a request with any
//            address bit above ADDR_W+1 set is rejected as out of range.
//            When undefined, those bits are ignored and the address wraps.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_rd
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;

  logic              req_misaligned;
  logic              req_oob;
  logic              req_bad;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

`ifdef DMEM_LSU_BOUNDS_CHECK_EN
  assign req_oob = |req_addr[31:ADDR_W+2];
`else
  // Upper address bits are deliberately dropped so the address wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign req_oob        = 1'b0;
`endif

  // Alignment: halves need addr[0]=0, words (and reserved size) need addr[1:0]=0.
  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      2'd0:    req_misaligned = 1'b0;
      2'd1:    req_misaligned = req_addr[0];
      default: req_misaligned = |req_addr[1:0];
    endcase
  end

  assign req_bad = req_misaligned | req_oob;

  // Lane extraction and extension of the memory word for loads.
  always_comb begin
    byte_sel = mem_rd[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (size_q)
      2'd0:    load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'd1:    load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_rd;
    endcase
  end

  // Sub-word store merge: replace the addressed lane of the word just read.
  always_comb begin
    merged = mem_rd;
    if (size_q == 2'd0) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Next-state and datapath update; request fields only captured in IDLE.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    size_d   = size_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          lane_d   = req_addr[1:0];
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata[15:0];
          addr_d   = req_addr[ADDR_W+1:2];
          if (req_bad) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (!req_we) begin
            state_d = S_LOAD;
          end else if (req_size[1]) begin
            wd_d    = req_wdata;
            state_d = S_WRITE;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        rdata_d = load_ext;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        wd_d    = merged;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lane_q   <= 2'd0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      wdata_q  <= 16'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wd_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
    end
  end

  // Strobes come straight from the state; the write is blocked during reset
  // so an interrupted store never reaches memory.
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign mem_read   = (state_q == S_LOAD) || (state_q == S_RMW_RD);
  assign mem_write  = (state_q == S_WRITE) && !rst;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = addr_q;
  assign mem_wd     = wd_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Brief    : Self-checking bench for dmem_lsu with a behavioural memory
//            model, directed cases and randomized requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic              mem_write;
  logic              mem_read;
  logic [31:0]       mem_rd;

  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        mem_init;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rd     (mem_rd)
  );

  // Data memory: combinational read, write on posedge.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 32'(i);
    end else if (mem_write) begin
      tb_mem[mem_addr] <= mem_wd;
    end
  end
  assign mem_rd = tb_mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: model the expected outcome, drive it, watch every cycle
  // until the response, then compare.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic        mis, oob, exp_err, got, both;
    logic [31:0] word, v, merged, exp_rd, rd_addr, wr_addr, wr_data;
    int          widx, sh, exp_lat, exp_nrd, exp_nwr, nrd, nwr, k;

    mis = (size == 2'd1 && (addr % 2) != 0) || (size >= 2'd2 && (addr % 4) != 0);
    oob = 1'b0;
`ifdef DMEM_LSU_BOUNDS_CHECK_EN
    oob = (addr >= 32'd256);
`endif
    widx   = int'((addr / 4) % DEPTH);
    sh     = int'(addr % 4) * 8;
    word   = ref_mem[widx];
    merged = 32'd0;
    exp_rd = 32'd0;
    if (mis || oob) begin
      exp_lat = 1; exp_nrd = 0; exp_nwr = 0; exp_err = 1'b1;
    end else if (!we) begin
      exp_lat = 2; exp_nrd = 1; exp_nwr = 0; exp_err = 1'b0;
      if (size == 2'd0) begin
        v = (word >> sh) & 32'hFF;
        if (sgn && v >= 32'd128) v = v | 32'hFFFFFF00;
      end else if (size == 2'd1) begin
        v = (word >> sh) & 32'hFFFF;
        if (sgn && v >= 32'd32768) v = v | 32'hFFFF0000;
      end else begin
        v = word;
      end
      exp_rd = v;
    end else begin
      exp_nwr = 1; exp_err = 1'b0;
      if (size >= 2'd2) begin
        merged = wd; exp_lat = 2; exp_nrd = 0;
      end else if (size == 2'd0) begin
        merged = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        exp_lat = 3; exp_nrd = 1;
      end else begin
        merged = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        exp_lat = 3; exp_nrd = 1;
      end
      ref_mem[widx] = merged;
    end

    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    chk("req_ready_busy", 32'(req_ready), 32'd0);

    nrd = 0; nwr = 0; k = 0; got = 1'b0; both = 1'b0;
    rd_addr = 32'd0; wr_addr = 32'd0; wr_data = 32'd0;
    while (!got && k < 6) begin
      k++;
      // Noise on the request inputs while busy must be ignored.
      req_valid  = 1'b1;
      req_we     = 1'($urandom_range(0, 1));
      req_size   = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      if (mem_read === 1'b1) begin nrd++; rd_addr = 32'(mem_addr); end
      if (mem_write === 1'b1) begin nwr++; wr_addr = 32'(mem_addr); wr_data = mem_wd; end
      if (mem_read === 1'b1 && mem_write === 1'b1) both = 1'b1;
      if (resp_valid === 1'b1) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("resp_seen", 32'(got), 32'd1);
    chk("latency", 32'(k), 32'(exp_lat));
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    chk("mem_read_cycles", 32'(nrd), 32'(exp_nrd));
    chk("mem_write_cycles", 32'(nwr), 32'(exp_nwr));
    chk("rd_wr_exclusive", 32'(both), 32'd0);
    if (exp_nrd == 1) chk("mem_addr_read", rd_addr, 32'(widx));
    if (exp_nwr == 1) begin
      chk("mem_addr_write", wr_addr, 32'(widx));
      chk("mem_wd", wr_data, merged);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    chk("resp_rdata_hold", resp_rdata, exp_rd);
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    mem_init = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);         // load word -> 5
    do_req(1'b1, 2'd0, 1'b0, 32'h09, 32'h80);        // store byte -> 0x8002
    do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h09, 32'h0);         // 0xFFFFFF80
    do_req(1'b0, 2'd0, 1'b0, 32'h09, 32'h0);         // 0x00000080
    do_req(1'b0, 2'd1, 1'b1, 32'h08, 32'h0);         // 0xFFFF8002
    do_req(1'b0, 2'd1, 1'b0, 32'h03, 32'h0);         // misaligned half
    do_req(1'b1, 2'd2, 1'b0, 32'h06, 32'h12345678);  // misaligned word
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);        // out of range / wrap
    do_req(1'b1, 2'd1, 1'b0, 32'h2A, 32'hCAFEBABE);  // store upper half
    do_req(1'b0, 2'd3, 1'b0, 32'h28, 32'h0);         // reserved size as word

    // Reset landing on the WRITE cycle of a word store.
    chk("pre_rst_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0C; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("write_cycle_strobe", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("write_gated_by_rst", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
    chk("word3_unchanged", tb_mem[3], 32'h3);

    // Randomized requests.
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & ~32'h1;
        else if (sz >= 2'd2) a = a & ~32'h3;
      end
      if ($urandom_range(0, 9) == 0) a = a | ($urandom << 8);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    for (int i = 0; i < DEPTH; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
